// File: rtl/square_animator.sv
// square_animator: frame-paced erase/move/redraw controller driving the square drawer
module square_animator #(
    parameter int SIZE        = 10,
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int STEP        = 1,
    parameter int FRAME_TICKS = 833333,
    parameter int X_INIT      = 0,
    parameter int Y_INIT      = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        drawer_done,
    output logic        drawer_start,
    output logic [10:0] x0,
    output logic [10:0] y0,
    output logic        color,
    output logic        busy,
    output logic        frame_done
);
    localparam int XMAX = SCREEN_W - 1 - SIZE;
    localparam int YMAX = SCREEN_H - 1 - SIZE;
    localparam int TW   = $clog2(FRAME_TICKS);
    localparam logic [10:0] XMAX_L = 11'(XMAX);
    localparam logic [10:0] YMAX_L = 11'(YMAX);
    localparam logic [10:0] STEP_L = 11'(STEP);
    localparam logic [TW-1:0] TICK_LAST = TW'(FRAME_TICKS - 1);
    localparam logic [2:0] S_WAIT       = 3'd0;
    localparam logic [2:0] S_ERASE      = 3'd1;
    localparam logic [2:0] S_ERASE_WAIT = 3'd2;
    localparam logic [2:0] S_MOVE       = 3'd3;
    localparam logic [2:0] S_SETTLE     = 3'd4;
    localparam logic [2:0] S_DRAW       = 3'd5;
    localparam logic [2:0] S_DRAW_WAIT  = 3'd6;

    logic [2:0]    r_state;
    logic [TW-1:0] r_tick;
    logic [1:0]    r_settle;
    logic [10:0]   r_x;
    logic [10:0]   r_y;
    logic          r_dir_x;
    logic          r_dir_y;
    logic          r_drawn;
    logic          r_color;
    logic          r_frame_done;

    logic [2:0]    w_next;
    logic          w_frame_go;
    logic [11:0]   w_x_up;
    logic [11:0]   w_y_up;
    logic          w_x_hit_hi;
    logic          w_y_hit_hi;
    logic          w_x_hit_lo;
    logic          w_y_hit_lo;
    logic [10:0]   w_x_next;
    logic [10:0]   w_y_next;
    logic          w_dir_x_next;
    logic          w_dir_y_next;

    assign w_frame_go   = enable && (r_tick == TICK_LAST);
    assign drawer_start = (r_state == S_ERASE) || (r_state == S_DRAW);
    assign busy         = r_state != S_WAIT;
    assign color        = r_color;
    assign frame_done   = r_frame_done;
    assign x0           = r_x;
    assign y0           = r_y;

    // Next position and direction per axis; the clamp at each edge also reverses travel
    always_comb begin
        w_x_up       = {1'b0, r_x} + {1'b0, STEP_L};
        w_y_up       = {1'b0, r_y} + {1'b0, STEP_L};
        w_x_hit_hi   = w_x_up >= {1'b0, XMAX_L};
        w_y_hit_hi   = w_y_up >= {1'b0, YMAX_L};
        w_x_hit_lo   = r_x <= STEP_L;
        w_y_hit_lo   = r_y <= STEP_L;
        w_x_next     = r_dir_x ? (w_x_hit_hi ? XMAX_L : w_x_up[10:0]) : (w_x_hit_lo ? 11'd0 : r_x - STEP_L);
        w_y_next     = r_dir_y ? (w_y_hit_hi ? YMAX_L : w_y_up[10:0]) : (w_y_hit_lo ? 11'd0 : r_y - STEP_L);
        w_dir_x_next = r_dir_x ? !w_x_hit_hi : w_x_hit_lo;
        w_dir_y_next = r_dir_y ? !w_y_hit_hi : w_y_hit_lo;
    end

    // Sequence selection: a frame erases only once something has been drawn
    always_comb begin
        w_next = S_WAIT;
        case (r_state)
            S_WAIT:       w_next = w_frame_go ? (r_drawn ? S_ERASE : S_DRAW) : S_WAIT;
            S_ERASE:      w_next = S_ERASE_WAIT;
            S_ERASE_WAIT: w_next = drawer_done ? S_MOVE : S_ERASE_WAIT;
            S_MOVE:       w_next = S_SETTLE;
            S_SETTLE:     w_next = (r_settle == 2'd1) ? S_DRAW : S_SETTLE;
            S_DRAW:       w_next = S_DRAW_WAIT;
            S_DRAW_WAIT:  w_next = drawer_done ? S_WAIT : S_DRAW_WAIT;
            default:      w_next = S_WAIT;
        endcase
    end

    // State, frame pacing, settle delay, motion and drawer-facing registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_WAIT;
            r_tick       <= '0;
            r_settle     <= 2'd0;
            r_x          <= 11'(X_INIT);
            r_y          <= 11'(Y_INIT);
            r_dir_x      <= 1'b1;
            r_dir_y      <= 1'b1;
            r_drawn      <= 1'b0;
            r_color      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_frame_done <= (r_state == S_DRAW_WAIT) && drawer_done;
            if (r_state == S_WAIT && enable)
                r_tick <= w_frame_go ? '0 : r_tick + TW'(1);
            if (r_state == S_SETTLE)
                r_settle <= (r_settle == 2'd1) ? 2'd0 : r_settle + 2'd1;
            if (r_state == S_MOVE) begin
                r_x     <= w_x_next;
                r_y     <= w_y_next;
                r_dir_x <= w_dir_x_next;
                r_dir_y <= w_dir_y_next;
            end
            if (r_state == S_DRAW_WAIT && drawer_done)
                r_drawn <= 1'b1;
            if (w_next == S_ERASE)
                r_color <= 1'b0;
            else if (w_next == S_DRAW)
                r_color <= 1'b1;
        end
    end
endmodule

// File: doc/square_animator.md
Name: square_animator

Overview:
- Frame-paced controller that sits directly upstream of the square drawer.
- Each frame it erases the square at its current corner, steps the position with edge bounce, then redraws at the new corner.
- It drives the drawer's start/x0/y0 handshake and supplies the pixel colour to the framebuffer write path.
- It is the motion source for the bouncing-square demo.

Parameters:
- SIZE, 10: square extent; the drawer covers x0..x0+SIZE and y0..y0+SIZE inclusive.
- SCREEN_W, 640: screen width in pixels.
- SCREEN_H, 480: screen height in pixels.
- STEP, 1: pixels moved per frame on each axis; must satisfy 1 <= STEP <= XMAX and STEP <= YMAX.
- FRAME_TICKS, 833333: clock cycles per frame; must be >= 4.
- X_INIT, 0: reset x corner; must be <= XMAX.
- Y_INIT, 0: reset y corner; must be <= YMAX.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- enable  input  1  permits new frames to start.
- drawer_done  input  1  one-cycle completion pulse from the square drawer.
- drawer_start  output  1  one-cycle request to the square drawer.
- x0  output  11  square corner x, sent to the drawer.
- y0  output  11  square corner y, sent to the drawer.
- color  output  1  0 = erase (black), 1 = draw (white); goes to the framebuffer write path.
- busy  output  1  high in every state except WAIT.
- frame_done  output  1  one-cycle pulse after each redraw completes.

Behaviour:
- Interface: clock clk; reset is synchronous, active-high. All state is registered on posedge clk.
- Derived bounds: XMAX = SCREEN_W-1-SIZE; YMAX = SCREEN_H-1-SIZE.
- Registers:
  - x_pos, y_pos: 11-bit, unsigned.
  - dir_x, dir_y: 1 = increasing.
  - drawn flag.
  - tick_cnt: sized for FRAME_TICKS.
  - settle_cnt: 2-bit.
- Reset values:
  - State WAIT; tick_cnt = 0; settle_cnt = 0.
  - x_pos = X_INIT, y_pos = Y_INIT; dir_x = dir_y = 1; drawn = 0.
  - drawer_start = 0, color = 0, busy = 0, frame_done = 0.
- Output mapping: x0 = x_pos, y0 = y_pos at all times. Position changes only in MOVE, so x0/y0 stay stable while the drawer is busy.
- States:
  - WAIT:
    - While enable, tick_cnt increments each cycle; while !enable, tick_cnt holds.
    - When tick_cnt == FRAME_TICKS-1 and enable: tick_cnt <= 0, next state is ERASE if drawn, else DRAW.
  - ERASE: drawer_start = 1, color = 0, for exactly one cycle; then ERASE_WAIT.
  - ERASE_WAIT: drawer_start = 0, color = 0; stays until drawer_done = 1, then MOVE.
  - MOVE (1 cycle), per axis (x shown, y identical with YMAX):
    - dir_x = 1 and x_pos+STEP >= XMAX: x_pos <= XMAX, dir_x <= 0.
    - dir_x = 1 otherwise: x_pos <= x_pos+STEP.
    - dir_x = 0 and x_pos <= STEP: x_pos <= 0, dir_x <= 1.
    - dir_x = 0 otherwise: x_pos <= x_pos-STEP.
    - The two axes update independently in the same cycle, so a corner hit flips both directions.
    - Next state SETTLE.
  - SETTLE: 2 cycles (settle_cnt) so the drawer can return to idle; then DRAW.
  - DRAW: drawer_start = 1, color = 1, for one cycle; then DRAW_WAIT.
  - DRAW_WAIT:
    - color = 1; waits for drawer_done.
    - On drawer_done: drawn <= 1, frame_done <= 1 (registered, so high during the first WAIT cycle only), next state WAIT.
- color holds its last value in WAIT.
- Frame pacing: the first drawer_start occurs FRAME_TICKS cycles after reset deasserts with enable held high. This is never earlier than cycle 4, which guarantees the drawer is past its boot state.
- drawer_start is never asserted in the same cycle drawer_done is sampled. It is asserted no sooner than 3 cycles after any drawer_done.
- enable deasserted mid-frame: the in-progress erase/move/draw sequence completes. After that, no new drawer_start until enable returns; tick_cnt resumes from its held value.
- drawer_done outside ERASE_WAIT/DRAW_WAIT: ignored.
- Reset mid-operation: all registers return to reset values the next cycle, including drawn = 0, so the next frame draws without erasing. The drawer shares the same reset.

Test Plan:
Common bench settings: SIZE=10, SCREEN_W=64, SCREEN_H=48 (XMAX=53, YMAX=37), STEP=4, FRAME_TICKS=4. The bench uses a drawer model that pulses done 5 cycles after start.
1. Reset release with enable=1:
   - Outputs 0 during reset; x0=0, y0=0.
   - First drawer_start 4 cycles later with color=1, with no erase pass.
   - frame_done pulses once after the model's done.
2. Second frame:
   - Erase start with x0=0, y0=0, color=0.
   - Next start ≥3 cycles after done, with x0=4, y0=4, color=1.
   - x0/y0 constant during both waits.
3. X_INIT=49, Y_INIT=20, dir right: the move yields x0=53 with dir_x=0; the following frame yields x0=49, y0 advances 20→24→28.
4. X_INIT=52, Y_INIT=36 (corner): the move yields (53,37); the next move yields (49,33), confirming both axes flipped.
5. enable dropped 1 cycle after the erase start:
   - Erase and draw still complete.
   - No further drawer_start for 50 cycles.
   - Re-enable: the next start follows after the remaining ticks.
6. Reset asserted during DRAW_WAIT:
   - Next cycle: busy=0, drawer_start=0, x0/y0 = init values.
   - A later drawer_done pulse is ignored.
   - The first post-reset start has color=1 (no erase).
